// File: rtl/ad574_pkg.sv
// Shared encodings for the AD574 sampler: FSM states, timing-stage select and op codes.
// The READ_LO_* states are only reachable when AD574_BYTE_READ_EN is defined.
package ad574_pkg;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        CONV_REQ     = 4'd1,
        CONV_WAIT_HI = 4'd2,
        CONV_WAIT_LO = 4'd3,
        READ_REQ     = 4'd4,
        READ_WAIT    = 4'd5,
        PUSH         = 4'd6,
        READ_LO_REQ  = 4'd7,
        READ_LO_WAIT = 4'd8
    } state_t;

    // {S12_8n, AO} select presented to the timing stage
    localparam logic [1:0] ADDR_CONV = 2'b00;
    localparam logic [1:0] ADDR_HI   = 2'b00;
    localparam logic [1:0] ADDR_LO   = 2'b01;
    localparam logic [1:0] ADDR_FULL = 2'b10;

    localparam logic OP_CONV = 1'b0;
    localparam logic OP_READ = 1'b1;

    function automatic logic [15:0] sat_add16(input logic [15:0] value, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, value} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/ad574_trig_gen.sv
// Trigger source: free-running period counter gated by enable, merged with the external pulse.
module ad574_trig_gen #(
    parameter int unsigned SAMPLE_PERIOD = 100000
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic trig,
    output logic trig_evt
);

    localparam logic [31:0] PERIOD_LAST = 32'(SAMPLE_PERIOD - 1);

    logic [31:0] period_cnt;
    logic        auto_fire;

    assign auto_fire = enable && (period_cnt == PERIOD_LAST);
    // Coincident external and auto triggers collapse into a single event.
    assign trig_evt  = trig || auto_fire;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            period_cnt <= 32'd0;
        end else if (!enable || auto_fire) begin
            period_cnt <= 32'd0;
        end else begin
            period_cnt <= period_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ad574_sampler.sv
// AD574 sequencer: convert, wait, read, then hand the sample to a one-entry valid/ready register.
// Define AD574_BYTE_READ_EN for the 8-bit bus variant (high byte read then low nibble read).
module ad574_sampler
    import ad574_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned TIMEOUT_CYC   = 2000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        trig,
    output logic        op_req,
    output logic        op,
    output logic [1:0]  addr,
    input  logic        busy,
    input  logic [11:0] data,
    input  logic        data_valid,
    output logic [11:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] overrun_cnt,
    output logic        timeout_err,
    output logic [3:0]  fsm_state
);

    // Output handshake: a sample transfers on any cycle with m_valid && m_ready.
    // m_valid, once raised, stays high with m_data stable until that transfer;
    // m_ready may toggle freely and has no combinational path to m_valid.

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nx;
    logic        trig_evt;
    logic        in_wait;
    logic        in_read_wait;
    logic        tmo_hit;
    logic        tmo_fire;
    logic [31:0] tmo_cnt;
    logic        got_data;
    logic        trig_lost;
    logic        push_load;
    logic        push_drop;
    logic [11:0] sample;

`ifdef AD574_BYTE_READ_EN
    logic [7:0]  hi_q;
    logic [3:0]  lo_q;

    assign sample       = {hi_q, lo_q};
    assign in_read_wait = (state == READ_WAIT) || (state == READ_LO_WAIT);
    assign op_req       = (state == CONV_REQ) || (state == READ_REQ) || (state == READ_LO_REQ);
`else
    logic [11:0] stage_q;

    assign sample       = stage_q;
    assign in_read_wait = (state == READ_WAIT);
    assign op_req       = (state == CONV_REQ) || (state == READ_REQ);
`endif

    assign in_wait   = (state == CONV_WAIT_HI) || (state == CONV_WAIT_LO) || in_read_wait;
    assign tmo_hit   = in_wait && (tmo_cnt == TMO_LAST);
    // Inside a wait state the only path back to IDLE is the timeout.
    assign tmo_fire  = tmo_hit && (state_nx == IDLE);
    assign fsm_state = state;

    ad574_trig_gen #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_trig_gen (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .trig    (trig),
        .trig_evt(trig_evt)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        trig_lost = 1'b0;
        push_load = 1'b0;
        push_drop = 1'b0;
        case (state)
            IDLE: begin
                if (trig_evt) begin
                    // The timing stage cannot be aborted, so never start while it is busy.
                    if (busy) trig_lost = 1'b1;
                    else      state_nx  = CONV_REQ;
                end
            end
            CONV_REQ:     state_nx = CONV_WAIT_HI;
            CONV_WAIT_HI: begin
                if (busy)         state_nx = CONV_WAIT_LO;
                else if (tmo_hit) state_nx = IDLE;
            end
            CONV_WAIT_LO: begin
                if (!busy)        state_nx = READ_REQ;
                else if (tmo_hit) state_nx = IDLE;
            end
            READ_REQ:     state_nx = READ_WAIT;
            READ_WAIT: begin
                if (!busy && (got_data || data_valid)) begin
`ifdef AD574_BYTE_READ_EN
                    state_nx = READ_LO_REQ;
`else
                    state_nx = PUSH;
`endif
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                end
            end
`ifdef AD574_BYTE_READ_EN
            READ_LO_REQ:  state_nx = READ_LO_WAIT;
            READ_LO_WAIT: begin
                if (!busy && (got_data || data_valid)) state_nx = PUSH;
                else if (tmo_hit)                      state_nx = IDLE;
            end
`endif
            PUSH: begin
                state_nx = IDLE;
                if (!m_valid || m_ready) push_load = 1'b1;
                else                     push_drop = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (trig_evt && (state != IDLE)) trig_lost = 1'b1;
    end

    // Command select and per-command bookkeeping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op       <= OP_CONV;
            addr     <= ADDR_FULL;
            tmo_cnt  <= 32'd0;
            got_data <= 1'b0;
        end else begin
            // op/addr change only on entry to a REQ state and hold for the whole command.
            if (state_nx == CONV_REQ) begin
                op   <= OP_CONV;
                addr <= ADDR_CONV;
            end
            if (state_nx == READ_REQ) begin
                op <= OP_READ;
`ifdef AD574_BYTE_READ_EN
                addr <= ADDR_HI;
`else
                addr <= ADDR_FULL;
`endif
            end
`ifdef AD574_BYTE_READ_EN
            if (state_nx == READ_LO_REQ) begin
                op   <= OP_READ;
                addr <= ADDR_LO;
            end
`endif
            if (in_wait) tmo_cnt <= tmo_cnt + 32'd1;
            else         tmo_cnt <= 32'd0;

            if (op_req)                          got_data <= 1'b0;
            else if (in_read_wait && data_valid) got_data <= 1'b1;
        end
    end

`ifdef AD574_BYTE_READ_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hi_q <= 8'd0;
            lo_q <= 4'd0;
        end else begin
            if ((state == READ_WAIT) && data_valid)    hi_q <= data[11:4];
            if ((state == READ_LO_WAIT) && data_valid) lo_q <= data[11:8];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_q <= 12'd0;
        end else if ((state == READ_WAIT) && data_valid) begin
            stage_q <= data;
        end
    end
`endif

    // Holding register, overrun counter and sticky timeout
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_data      <= 12'd0;
            m_valid     <= 1'b0;
            overrun_cnt <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            if (push_load) begin
                m_data  <= sample;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            overrun_cnt <= sat_add16(overrun_cnt, {1'b0, trig_lost} + {1'b0, push_drop});
            if (tmo_fire) timeout_err <= 1'b1;
        end
    end

endmodule

// File: doc/ad574_sampler.md
Name: ad574_sampler

Overview:
- Sequencer directly upstream of the AD574 timing stage.
- Issues a convert command, waits for completion, then issues a 12-bit parallel read and captures the result.
- Presents each sample on a valid/ready output with a one-entry holding register.
- Triggered by an internal period timer or an external pulse; counts overruns and flags conversion timeouts.

Parameters:
- SAMPLE_PERIOD, 100000: clk cycles between auto triggers; legal range 2..2^32-1.
- TIMEOUT_CYC, 2000: clk cycles allowed per command with timing-stage busy high before timeout_err is set.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- enable  in  1  1 = period timer runs and auto triggers fire
- trig  in  1  single-cycle external trigger, honoured regardless of enable
- op_req  out  1  command strobe to timing stage
- op  out  1  0 = convert, 1 = read
- addr  out  2  {S12_8n,AO} select to timing stage
- busy  in  1  timing stage busy
- data  in  12  timing stage read data
- data_valid  in  1  one-cycle strobe qualifying data
- m_data  out  12  sample output
- m_valid  out  1  sample present
- m_ready  in  1  consumer accepts when m_valid&&m_ready
- overrun_cnt  out  16  triggers lost, saturating
- timeout_err  out  1  sticky error, cleared only by reset

Behaviour:
- Reset values: op_req=0, op=0, addr=2'b10, m_data=0, m_valid=0, overrun_cnt=0, timeout_err=0, period counter=0, state=IDLE.
- Trigger event: trig=1, or (enable=1 and period counter reaching SAMPLE_PERIOD-1).
  - Counter wraps to 0 when it fires.
  - Counter holds at 0 while enable=0.
  - If both sources fire in the same cycle, they count as one trigger.
- FSM states: IDLE, CONV_REQ, CONV_WAIT_HI, CONV_WAIT_LO, READ_REQ, READ_WAIT, PUSH.
- IDLE: on a trigger with busy=0, go to CONV_REQ. A trigger while busy=1 (including the post-reset busy from the timing stage) increments overrun_cnt and is dropped.
- CONV_REQ: op_req=1 for exactly one cycle, op=0, addr=2'b00. Next state CONV_WAIT_HI.
- CONV_WAIT_HI: wait for busy=1, then go to CONV_WAIT_LO. busy rises one cycle after op_req because it is registered in the timing stage.
- CONV_WAIT_LO: wait for busy=0, then go to READ_REQ.
- READ_REQ: op_req=1 for one cycle, op=1, addr=2'b10. Next state READ_WAIT.
- READ_WAIT: capture data into a staging register on data_valid, then wait for busy=0 and go to PUSH.
- PUSH:
  - If m_valid=0, or m_valid&&m_ready this cycle: load m_data, set m_valid=1, go to IDLE.
  - Otherwise the sample is dropped, overrun_cnt increments, go to IDLE. The holding register keeps the older sample.
- op and addr hold their value from the REQ state until the next REQ state. They must be stable for the whole command, because the timing stage samples them continuously.
- Triggers arriving outside IDLE increment overrun_cnt and are otherwise ignored.
- overrun_cnt saturates at 16'hFFFF.
- Timeout:
  - A per-command cycle counter runs in CONV_WAIT_HI, CONV_WAIT_LO and READ_WAIT, and clears on entry to each REQ state.
  - Reaching TIMEOUT_CYC sets timeout_err and forces IDLE.
  - The timing stage cannot be aborted, so IDLE still obeys the busy check before starting.
  - CONV_WAIT_HI is covered by the same timeout.
- m_valid clears on m_valid&&m_ready unless it is reloaded in the same cycle.
- Reset mid-command: all state returns to reset values; no output handshake completes.

Optional Feature:
- Macro: AD574_BYTE_READ_EN.
- Defined: 8-bit bus read sequence. After the convert, issue two reads:
  - addr=2'b00 captures data[11:4] as the upper byte.
  - addr=2'b01 captures data[11:8] as the low nibble.
  - m_data = {hi[7:0], lo[3:0]}.
  - Adds states READ_LO_REQ and READ_LO_WAIT, with the same busy/timeout rules.
- Undefined: single 12-bit read at addr=2'b10, as above.

Decomposition:
- Shared package ad574_pkg:
  - FSM state encoding.
  - Address constants: ADDR_CONV=2'b00, ADDR_HI=2'b00, ADDR_LO=2'b01, ADDR_FULL=2'b10.
  - Op constants: OP_CONV=0, OP_READ=1.
- Sub-module ad574_trig_gen: period counter, trigger merge, enable gating; outputs a one-cycle trig_evt.

Test Plan:
- Setup: SAMPLE_PERIOD=50, enable=1, timing-stage model with 40-cycle conversion, m_ready=1. Expect a convert then a read every 50 cycles; data 12'hA5C yields m_data=12'hA5C and a one-cycle m_valid.
- Command shape: trig pulse at IDLE, enable=0. Expect op_req high exactly 1 cycle, op=0/addr=00 held until READ_REQ, then op=1/addr=10 held until the next command.
- Backpressure: m_ready=0 for three samples. Expect m_data to keep the first sample and overrun_cnt=2; after m_ready=1, m_valid drops, and the next sample is delivered.
- Trigger collision: trig pulses 5 cycles after an auto trigger and again in the same cycle as an auto trigger. Expect overrun_cnt=1 and one completed sample per accepted trigger.
- Timeout: model holds busy=1 (STS stuck), TIMEOUT_CYC=100. Expect timeout_err=1 at 100 cycles, FSM in IDLE, no new op_req until busy=0. Also assert rstn=0 mid-read and check all outputs return to reset values the next cycle.
- With AD574_BYTE_READ_EN defined: model returns 8'hC3 at addr 00 and 4'h7 at addr 01. Expect m_data=12'hC37 and exactly three op_req pulses per sample.
